// File: rtl/cpu_defs_pkg.sv
// ============================================================================
// cpu_defs : shared CPU definitions (opcodes, access sizes, data-bridge FSM)
// Rev 1.1  : added access-size codes and dmem_bridge state encoding
// ============================================================================
`default_nettype none

package cpu_defs;

  // Primary opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Memory access size codes
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Data-side bridge FSM
  localparam int BRIDGE_ST_W = 2;

  typedef enum logic [BRIDGE_ST_W-1:0] {
    BR_IDLE = 2'b00,
    BR_ADDR = 2'b01,
    BR_DATA = 2'b10,
    BR_DONE = 2'b11
  } bridge_state_e;

endpackage

`default_nettype wire

// File: rtl/dmem_bridge_align_chk.sv
// ============================================================================
// dmem_align_chk : combinational misalignment detector for ME-stage accesses
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module dmem_align_chk
  import cpu_defs::*;
(
  input  logic       en_i,       // an access is presented this cycle
  input  logic       wr_i,       // 1 = store, 0 = load
  input  logic [1:0] size_i,     // access size code
  input  logic [1:0] addr_lo_i,  // low address bits
  output logic       adel_o,     // misaligned load
  output logic       ades_o      // misaligned store
);

  logic w_misalign;

  // Word needs addr[1:0]==0, half needs addr[0]==0; bytes are always aligned
  always_comb begin
    w_misalign = 1'b0;
    if (size_i == SIZE_WORD) begin
      w_misalign = (addr_lo_i != 2'b00);
    end else if (size_i == SIZE_HALF) begin
      w_misalign = addr_lo_i[0];
    end
  end

  assign adel_o = en_i & w_misalign & ~wr_i;
  assign ades_o = en_i & w_misalign &  wr_i;

endmodule

`default_nettype wire

// File: rtl/dmem_bridge.sv
// ============================================================================
// dmem_bridge : ME-stage load/store to split-transaction SRAM-like bus bridge
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module dmem_bridge
  import cpu_defs::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,            // async, active low
  // ME stage side
  input  logic                mem_en_i,
  input  logic [DATA_W/8-1:0] mem_wen_i,
  input  logic [1:0]          mem_size_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic                pipe_stall_i,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_stall_o,
  output logic                mem_adel_o,
  output logic                mem_ades_o,
  // Bus side
  output logic                data_req_o,
  output logic                data_wr_o,
  output logic [1:0]          data_size_o,
  output logic [DATA_W/8-1:0] data_wstrb_o,
  output logic [ADDR_W-1:0]   data_addr_o,
  output logic [DATA_W-1:0]   data_wdata_o,
  input  logic                data_addr_ok_i,
  input  logic                data_data_ok_i,
  input  logic [DATA_W-1:0]   data_rdata_i
);

  localparam int STRB_W = DATA_W / 8;

  bridge_state_e       state_q;
  logic                req_q;
  logic                wr_q;
  logic [1:0]          size_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   hold_q;

  logic                w_wr;
  logic                w_adel;
  logic                w_ades;
  logic                w_issue;

  assign w_wr = |mem_wen_i;

  // Misaligned accesses are only reported from IDLE; elsewhere mem_en belongs
  // to an access already in flight or completed
  dmem_align_chk u_align_chk (
    .en_i      (mem_en_i && (state_q == BR_IDLE) && rst),
    .wr_i      (w_wr),
    .size_i    (mem_size_i),
    .addr_lo_i (mem_addr_i[1:0]),
    .adel_o    (w_adel),
    .ades_o    (w_ades)
  );

  assign w_issue = mem_en_i && !w_adel && !w_ades;

  // Bridge FSM: latches the request, runs the address and data phases
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BR_IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= '0;
    end else begin
      case (state_q)
        BR_IDLE: begin
          if (w_issue) begin
            addr_q  <= mem_addr_i;
            wdata_q <= mem_wdata_i;
            wstrb_q <= mem_wen_i;
            size_q  <= mem_size_i;
            wr_q    <= w_wr;
            req_q   <= 1'b1;
            state_q <= BR_ADDR;
          end
        end
        BR_ADDR: begin
          // A data_ok coincident with addr_ok is not a legal response here
          if (data_addr_ok_i) begin
            req_q   <= 1'b0;
            state_q <= BR_DATA;
          end
        end
        BR_DATA: begin
          if (data_data_ok_i) begin
            hold_q  <= data_rdata_i;
            state_q <= pipe_stall_i ? BR_DONE : BR_IDLE;
          end
        end
        BR_DONE: begin
          // Pipeline still holds the same instruction; do not re-issue it
          if (!pipe_stall_i) begin
            state_q <= BR_IDLE;
          end
        end
        default: begin
          state_q <= BR_IDLE;
        end
      endcase
    end
  end

  // Stall request and load-data return, bypassing the hold buffer on data_ok
  always_comb begin
    mem_stall_o = 1'b0;
    mem_rdata_o = hold_q;
    case (state_q)
      BR_IDLE: mem_stall_o = w_issue & rst;
      BR_ADDR: mem_stall_o = 1'b1;
      BR_DATA: begin
        mem_stall_o = ~data_data_ok_i;
        if (data_data_ok_i) begin
          mem_rdata_o = data_rdata_i;
        end
      end
      default: mem_stall_o = 1'b0;
    endcase
  end

  assign mem_adel_o   = w_adel;
  assign mem_ades_o   = w_ades;

  assign data_req_o   = req_q;
  assign data_wr_o    = wr_q;
  assign data_size_o  = size_q;
  assign data_wstrb_o = wstrb_q;
  assign data_addr_o  = addr_q;
  assign data_wdata_o = wdata_q;

endmodule

`default_nettype wire
